swd_host: RTL and testbench

- Serial Wire Debug initiator, i.e. a debug-probe engine.
- Converts single-transaction requests from a local bus into SWD wire packets on SWDCLK/SWDIO.
- Drives the same pin set as our SoC's SWD target port, so it connects directly to the target's TCK_SWDCLK/TMS_SWDIN/SWDOUT/SWDOUTEN.
- Used for loopback verification and for self-hosted debug of an on-FPGA core.

---
 rtl/swd_host.sv | 222 ++++++++++++++++++++++
 tb/tb_swd_host.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/swd_host.sv
// SWD initiator: turns single local-bus requests into SWDCLK/SWDIO packets.
// Each bit-time is CLK_DIV clocks low then CLK_DIV clocks high; SWDIN sampled at the end of high.
//
// state   | meaning
// IDLE    | line driven low, req_ready=1, waiting for a request
// LRESET  | 56 ones then 8 zeros
// REQ     | 8-bit request header, LSB first
// TRN1    | turnaround before ACK, line released
// ACK     | 3 ACK bits sampled
// RDATA   | 32 data bits + parity sampled
// TRN2    | turnaround after read or non-OK ACK
// TRN2W   | turnaround before write data
// WDATA   | 32 data bits + parity driven
// POST    | IDLE_CYCLES driven-low idle bits (IDLE_CYCLES >= 1)
// RESP    | one-cycle response strobe
module swd_host #(
  parameter int CLK_DIV     = 2,
  parameter int IDLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_lreset,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        SWDCLK,
  output logic        SWDOUT,
  output logic        SWDOUTEN,
  input  logic        SWDIN
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [5:0]    POST_LOAD = 6'(IDLE_CYCLES - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LRESET = 4'd1;
  localparam logic [3:0] S_REQ    = 4'd2;
  localparam logic [3:0] S_TRN1   = 4'd3;
  localparam logic [3:0] S_ACK    = 4'd4;
  localparam logic [3:0] S_RDATA  = 4'd5;
  localparam logic [3:0] S_TRN2   = 4'd6;
  localparam logic [3:0] S_TRN2W  = 4'd7;
  localparam logic [3:0] S_WDATA  = 4'd8;
  localparam logic [3:0] S_POST   = 4'd9;
  localparam logic [3:0] S_RESP   = 4'd10;

  logic [3:0]    state;
  logic [DW-1:0] div_cnt;
  logic          clk_hi;
  logic [5:0]    bit_cnt;
  logic [31:0]   sh;
  logic [31:0]   wdata_q;
  logic [2:0]    ack_sh;
  logic          rnw_q;
  logic          perr_q;
  logic          bit_end;
  logic [2:0]    ack_next;
  logic          req_par;
  logic          rd_ok;

  assign bit_end  = clk_hi && (div_cnt == '0);
  assign ack_next = {SWDIN, ack_sh[2:1]};
  assign req_par  = req_apndp ^ req_rnw ^ req_addr[0] ^ req_addr[1];
  assign rd_ok    = rnw_q && (ack_sh == 3'b001);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      clk_hi    <= 1'b0;
      bit_cnt   <= '0;
      sh        <= '0;
      wdata_q   <= '0;
      ack_sh    <= '0;
      rnw_q     <= 1'b0;
      perr_q    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_ack   <= '0;
      rsp_rdata <= '0;
      rsp_perr  <= 1'b0;
      SWDCLK    <= 1'b0;
      SWDOUT    <= 1'b0;
      SWDOUTEN  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // bit-time engine; the state case below overrides it on acceptance
      if (state != S_IDLE && state != S_RESP) begin
        if (div_cnt != '0) begin
          div_cnt <= div_cnt - DW'(1);
        end else begin
          div_cnt <= DIV_LOAD;
          clk_hi  <= !clk_hi;
          SWDCLK  <= !clk_hi;
        end
      end
      if (bit_end && bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;

      case (state)
        S_IDLE: begin
          SWDCLK    <= 1'b0;
          SWDOUTEN  <= 1'b1;
          SWDOUT    <= 1'b0;
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            div_cnt   <= DIV_LOAD;
            clk_hi    <= 1'b0;
            wdata_q   <= req_wdata;
            ack_sh    <= 3'b000;
            perr_q    <= 1'b0;
            SWDOUT    <= 1'b1;
            if (req_lreset) begin
              state   <= S_LRESET;
              bit_cnt <= 6'd63;
              rnw_q   <= 1'b0;
            end else begin
              state   <= S_REQ;
              bit_cnt <= 6'd7;
              rnw_q   <= req_rnw;
              sh      <= {24'd0, 1'b1, 1'b0, req_par, req_addr[1], req_addr[0],
                          req_rnw, req_apndp, 1'b1};
            end
          end
        end
        S_LRESET: if (bit_end) begin
          if (bit_cnt != 6'd0) begin
            SWDOUT <= (bit_cnt > 6'd8);
          end else begin
            SWDOUT    <= 1'b0;
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_ack   <= 3'b000;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
          end
        end
        S_REQ: if (bit_end) begin
          if (bit_cnt != 6'd0) begin
            sh     <= sh >> 1;
            SWDOUT <= sh[1];
          end else begin
            state    <= S_TRN1;
            bit_cnt  <= 6'd0;
            SWDOUT   <= 1'b0;
            SWDOUTEN <= 1'b0;
          end
        end
        S_TRN1: if (bit_end) begin
          state   <= S_ACK;
          bit_cnt <= 6'd2;
        end
        S_ACK: if (bit_end) begin
          ack_sh <= ack_next;
          if (bit_cnt == 6'd0) begin
            bit_cnt <= 6'd0;
            if (ack_next == 3'b001 && rnw_q) begin
              state   <= S_RDATA;
              bit_cnt <= 6'd32;
            end else if (ack_next == 3'b001) begin
              state <= S_TRN2W;
            end else begin
              state <= S_TRN2;
            end
          end
        end
        S_RDATA: if (bit_end) begin
          if (bit_cnt != 6'd0) begin
            sh <= {SWDIN, sh[31:1]};
          end else begin
            perr_q <= SWDIN ^ (^sh);
            state  <= S_TRN2;
          end
        end
        S_TRN2: if (bit_end) begin
          state    <= S_POST;
          bit_cnt  <= POST_LOAD;
          SWDOUTEN <= 1'b1;
          SWDOUT   <= 1'b0;
        end
        S_TRN2W: if (bit_end) begin
          state    <= S_WDATA;
          bit_cnt  <= 6'd32;
          sh       <= wdata_q;
          SWDOUTEN <= 1'b1;
          SWDOUT   <= wdata_q[0];
        end
        S_WDATA: if (bit_end) begin
          if (bit_cnt > 6'd1) begin
            sh     <= sh >> 1;
            SWDOUT <= sh[1];
          end else if (bit_cnt == 6'd1) begin
            SWDOUT <= ^wdata_q;
          end else begin
            state   <= S_POST;
            bit_cnt <= POST_LOAD;
            SWDOUT  <= 1'b0;
          end
        end
        S_POST: if (bit_end && bit_cnt == 6'd0) begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_ack   <= ack_sh;
          rsp_rdata <= rd_ok ? sh : 32'd0;
          rsp_perr  <= rd_ok ? perr_q : 1'b0;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_swd_host.sv
// Bench for swd_host: a behavioural SWD target answers on SWDIN, records the wire per bit-time,
// and each response is compared with values derived from the SWD packet rules.
module tb_swd_host;
  localparam int CLK_DIV     = 2;
  localparam int IDLE_CYCLES = 2;

  logic        CLK, RESETn;
  logic        req_valid, req_ready, req_lreset, req_apndp, req_rnw;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_perr;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        SWDCLK, SWDOUT, SWDOUTEN, SWDIN;

  swd_host #(.CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_lreset(req_lreset),
    .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .SWDCLK(SWDCLK), .SWDOUT(SWDOUT), .SWDOUTEN(SWDOUTEN), .SWDIN(SWDIN)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int bit_idx  = 0;
  int rsp_cnt  = 0;
  int rsp_cyc, rsp_bits, acc_cyc, rsp_base;
  logic [79:0] wire_out, wire_oe, resp_bits;
  logic [2:0]  r_ack;
  logic [31:0] r_rdata;
  logic        r_perr;

  bit          cur_lr, cur_ap, cur_rnw, cur_pflip;
  logic [1:0]  cur_a;
  logic [31:0] cur_wd, cur_rd;
  logic [2:0]  cur_ack;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  // target side: one bit per SWDCLK rise; the reply bit is stable for the whole high phase
  initial begin
    SWDIN = 1'b0;
    forever begin
      @(posedge SWDCLK);
      if (bit_idx < 80) begin
        wire_out[bit_idx] = SWDOUT;
        wire_oe[bit_idx]  = SWDOUTEN;
        SWDIN = resp_bits[bit_idx];
      end
      bit_idx++;
    end
  end

  always @(negedge CLK) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc  = cyc;
      rsp_bits = bit_idx;
      r_ack    = rsp_ack;
      r_rdata  = rsp_rdata;
      r_perr   = rsp_perr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input bit lr, input bit ap, input bit rnw, input logic [1:0] a,
                           input logic [31:0] wd, input logic [2:0] ack,
                           input logic [31:0] rd, input bit pflip);
    int n;
    cur_lr = lr; cur_ap = ap; cur_rnw = rnw; cur_a = a;
    cur_wd = wd; cur_ack = ack; cur_rd = rd; cur_pflip = pflip;
    resp_bits = '0;
    wire_out  = '0;
    wire_oe   = '0;
    if (!lr) begin
      for (int i = 0; i < 3; i++) resp_bits[9+i] = ack[i];
      if (ack == 3'b001 && rnw) begin
        for (int i = 0; i < 32; i++) resp_bits[12+i] = rd[i];
        resp_bits[44] = (^rd) ^ pflip;
      end
    end
    n = 0;
    @(negedge CLK);
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", 64'(n < 100), 64'd1);
    req_valid  = 1'b1;
    req_lreset = lr;
    req_apndp  = ap;
    req_rnw    = rnw;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    bit_idx   = 0;
    acc_cyc   = cyc;
    rsp_base  = rsp_cnt;
  endtask

  task automatic finish_txn();
    int n, nbits, lat, exp_lat;
    bit ok;
    logic [63:0] oe_obs, oe_exp;
    logic [7:0]  exp_byte;
    ok = !cur_lr && (cur_ack == 3'b001);
    n = 0;
    while (rsp_cnt == rsp_base && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("rsp_timeout", 64'(rsp_cnt != rsp_base), 64'd1);
    repeat (3) @(negedge CLK);
    chk("rsp_pulses", 64'(rsp_cnt - rsp_base), 64'd1);

    nbits   = cur_lr ? 64 : ((ok ? 46 : 13) + IDLE_CYCLES);
    exp_lat = 2 * CLK_DIV * nbits;
    lat     = rsp_cyc - acc_cyc;
    chk("bit_times", 64'(rsp_bits), 64'(nbits));
    chk("latency", 64'((lat >= exp_lat - 1 && lat <= exp_lat + 1) ? exp_lat : lat), 64'(exp_lat));

    chk("rsp_ack", 64'(r_ack), 64'(cur_lr ? 3'b000 : cur_ack));
    chk("rsp_rdata", 64'(r_rdata), 64'((ok && cur_rnw) ? cur_rd : 32'd0));
    chk("rsp_perr", 64'(r_perr), 64'((ok && cur_rnw) ? cur_pflip : 1'b0));

    oe_obs = '0;
    oe_exp = '0;
    for (int i = 0; i < nbits && i < 64; i++) begin
      oe_obs[i] = wire_oe[i];
      oe_exp[i] = 1'b1;
      if (!cur_lr) begin
        if (i >= 8 && i <= 12) oe_exp[i] = 1'b0;
        if (ok && cur_rnw && i >= 12 && i <= 45) oe_exp[i] = 1'b0;
      end
    end
    chk("swdouten", oe_obs, oe_exp);

    if (cur_lr) begin
      chk("lreset_wire", wire_out[63:0], 64'h00FF_FFFF_FFFF_FFFF);
    end else begin
      exp_byte = {1'b1, 1'b0, cur_ap ^ cur_rnw ^ cur_a[0] ^ cur_a[1],
                  cur_a[1], cur_a[0], cur_rnw, cur_ap, 1'b1};
      chk("req_byte", 64'(wire_out[7:0]), 64'(exp_byte));
      if (ok && !cur_rnw) begin
        chk("wdata_wire", 64'(wire_out[44:13]), 64'(cur_wd));
        chk("wdata_par", 64'(wire_out[45]), 64'(^cur_wd));
      end
    end
  endtask

  task automatic run_txn(input bit lr, input bit ap, input bit rnw, input logic [1:0] a,
                         input logic [31:0] wd, input logic [2:0] ack,
                         input logic [31:0] rd, input bit pflip);
    start_req(lr, ap, rnw, a, wd, ack, rd, pflip);
    finish_txn();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [2:0] ack_r;
    RESETn = 1'b0; req_valid = 1'b0; req_lreset = 1'b0; req_apndp = 1'b0;
    req_rnw = 1'b0; req_addr = 2'd0; req_wdata = 32'd0;
    resp_bits = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", 64'({SWDCLK, SWDOUT, SWDOUTEN, req_ready, rsp_valid, rsp_ack, rsp_perr}), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_outs", 64'({SWDCLK, SWDOUT, SWDOUTEN, req_ready}), 64'b0011);

    run_txn(0, 0, 1, 2'd0, 32'd0, 3'b001, 32'h2BA0_1477, 0);
    chk("req_byte_a5", 64'(wire_out[7:0]), 64'hA5);
    run_txn(0, 0, 1, 2'd0, 32'd0, 3'b001, 32'h2BA0_1477, 1);
    run_txn(0, 0, 0, 2'd1, 32'h5000_0000, 3'b001, 32'd0, 0);
    chk("req_byte_a9", 64'(wire_out[7:0]), 64'hA9);
    run_txn(0, 0, 1, 2'd0, 32'd0, 3'b010, 32'hDEAD_BEEF, 0);
    run_txn(1, 0, 0, 2'd0, 32'd0, 3'b000, 32'd0, 0);

    // abort in the high phase of read-data bit 10 (wire bit 22)
    start_req(0, 1, 1, 2'd3, 32'd0, 3'b001, 32'h1234_5678, 0);
    n = 0;
    while (bit_idx < 23 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reach", 64'(n < 500), 64'd1);
    base = rsp_cnt;
    RESETn = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_outs", 64'({SWDCLK, SWDOUT, SWDOUTEN, req_ready, rsp_valid, rsp_ack, rsp_perr}), 64'd0);
    chk("abort_rdata", 64'(rsp_rdata), 64'd0);
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    SWDIN  = 1'b0;
    repeat (2) @(negedge CLK);
    chk("abort_ready", 64'({req_ready, SWDOUTEN, SWDCLK}), 64'b110);
    repeat (20) @(negedge CLK);
    chk("abort_no_rsp", 64'(rsp_cnt - base), 64'd0);
    run_txn(0, 1, 1, 2'd2, 32'd0, 3'b001, 32'hCAFE_F00D, 0);

    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    ack_r = 3'b001;
        2:       ack_r = 3'b010;
        3:       ack_r = 3'b100;
        default: ack_r = 3'b111;
      endcase
      run_txn($urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom), 2'($urandom),
              $urandom, ack_r, $urandom, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
